// File: rtl/fetch_stage.sv
// Instruction fetch: PC register drives combinational imem, word lands in IF/ID one edge later.
// Stall freezes PC and IF/ID, redirect overrides stall and flushes; FETCH_COUNTER_EN adds a saturating fetch counter.
module fetch_stage #(
   parameter int unsigned NUM_INSTRUCTIONS = 12,
   parameter logic [31:0] RESET_PC         = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid,
   output logic        halted,
   output logic        misaligned,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] PC_LIMIT = 32'(4 * NUM_INSTRUCTIONS);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_if_id_instr;
   logic [31:0] r_if_id_pc;
   logic        r_if_id_valid;
   logic        r_halted;
   logic        r_misaligned;

   logic        w_in_range;
   logic        w_target_aligned;
   logic        w_capture;

   assign w_in_range       = (r_pc < PC_LIMIT);
   assign w_target_aligned = (redirect_target[1:0] == 2'b00);
   // A capture is the only event that loads if_id_valid with 1.
   assign w_capture        = (r_state == ST_RUN) && !redirect && !stall && w_in_range;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_if_id_instr <= 32'h0;
         r_if_id_pc    <= 32'h0;
         r_if_id_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_misaligned  <= 1'b0;
      end else begin
         case (r_state)
            ST_ERROR: begin
               r_if_id_valid <= 1'b0;
            end
            default: begin
               if (redirect) begin
                  r_pc          <= redirect_target;
                  r_if_id_valid <= 1'b0;
                  if (w_target_aligned) begin
                     r_state  <= ST_RUN;
                     r_halted <= 1'b0;
                  end else begin
                     r_state      <= ST_ERROR;
                     r_misaligned <= 1'b1;
                  end
               end else if (stall) begin
                  r_state <= r_state;
               end else if (w_capture) begin
                  r_if_id_instr <= imem_instr;
                  r_if_id_pc    <= r_pc;
                  r_if_id_valid <= 1'b1;
                  r_pc          <= r_pc + 32'd4;
               end else if (r_state == ST_RUN) begin
                  // Ran off the end of the program: park without capturing.
                  r_if_id_valid <= 1'b0;
                  r_state       <= ST_HALT;
                  r_halted      <= 1'b1;
               end else begin
                  r_if_id_valid <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef FETCH_COUNTER_EN
   logic [31:0] r_fetch_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_count <= 32'h0;
      end else if (w_capture && (r_fetch_count != 32'hFFFF_FFFF)) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign fetch_count = r_fetch_count;
`else
   assign fetch_count = 32'h0;
`endif

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign if_id_instr = r_if_id_instr;
   assign if_id_pc    = r_if_id_pc;
   assign if_id_valid = r_if_id_valid;
   assign halted      = r_halted;
   assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run to halt, stall, redirect, misalign and mid-run reset.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic        halted;
   logic        misaligned;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_stage #(
      .NUM_INSTRUCTIONS(12),
      .RESET_PC        (32'h0000_0000)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_target(redirect_target),
      .pc             (pc),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_valid    (if_id_valid),
      .halted         (halted),
      .misaligned     (misaligned),
      .fetch_count    (fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pc"}, pc, 32'h0);
      chk({tag, ".instr"}, if_id_instr, 32'h0);
      chk({tag, ".ifpc"}, if_id_pc, 32'h0);
      chk({tag, ".valid"}, 32'(if_id_valid), 32'd0);
      chk({tag, ".halted"}, 32'(halted), 32'd0);
      chk({tag, ".misal"}, 32'(misaligned), 32'd0);
      chk({tag, ".cnt"}, fetch_count, 32'd0);
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] fpc);
      chk({tag, ".valid"}, 32'(if_id_valid), 32'd1);
      chk({tag, ".ifpc"}, if_id_pc, fpc);
      chk({tag, ".instr"}, if_id_instr, mem_word(fpc));
      chk({tag, ".pc"}, pc, fpc + 32'd4);
   endtask

   initial begin
      rst_n           = 1'b0;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      step();
      chk_reset("reset");
      chk("reset.addr", imem_addr, 32'h0);

      // Free run over all 12 words, then halt.
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_fetch("run", 32'(4 * i));
      end
      chk("run.pc48", pc, 32'd48);
      chk("run.nohalt", 32'(halted), 32'd0);
      step();
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.valid", 32'(if_id_valid), 32'd0);
      chk("halt.pc", pc, 32'd48);
      chk("halt.ifpc", if_id_pc, 32'd44);
`ifdef FETCH_COUNTER_EN
      chk("halt.cnt", fetch_count, 32'd12);
`else
      chk("halt.cnt", fetch_count, 32'd0);
`endif
      step();
      chk("halt.stay", 32'(halted), 32'd1);

      // Leave HALT with a redirect to 0x4.
      redirect        = 1'b1;
      redirect_target = 32'h4;
      step();
      redirect = 1'b0;
      chk("rdh.pc", pc, 32'h4);
      chk("rdh.halted", 32'(halted), 32'd0);
      chk("rdh.valid", 32'(if_id_valid), 32'd0);
      step();
      chk_fetch("rdh.first", 32'h4);

      // Stall three cycles at pc=8.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_fetch("stall", 32'h4);
      end
      stall = 1'b0;
      step();
      chk_fetch("resume", 32'h8);

      // Redirect to 0x20 at pc=0xC with stall also asserted.
      chk("pre.pc", pc, 32'hC);
      stall           = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h20;
      step();
      stall    = 1'b0;
      redirect = 1'b0;
      chk("rds.pc", pc, 32'h20);
      chk("rds.valid", 32'(if_id_valid), 32'd0);
      chk("rds.ifpc", if_id_pc, 32'h8);
      step();
      chk_fetch("rds.first", 32'h20);
`ifdef FETCH_COUNTER_EN
      chk("rds.cnt", fetch_count, 32'd15);
`else
      chk("rds.cnt", fetch_count, 32'd0);
`endif

      // Mid-run reset at pc=0x18.
      redirect        = 1'b1;
      redirect_target = 32'h18;
      step();
      redirect = 1'b0;
      chk("mr.pc", pc, 32'h18);
      rst_n = 1'b0;
      stall = 1'b1;
      step();
      chk_reset("midrst");
      rst_n = 1'b1;
      stall = 1'b0;
      step();
      chk_fetch("mr.first", 32'h0);

      // Misaligned redirect, then ERROR ignores everything.
      redirect        = 1'b1;
      redirect_target = 32'h22;
      step();
      chk("mis.pc", pc, 32'h22);
      chk("mis.flag", 32'(misaligned), 32'd1);
      chk("mis.valid", 32'(if_id_valid), 32'd0);
      redirect_target = 32'h4;
      step();
      redirect = 1'b0;
      chk("err.pc", pc, 32'h22);
      chk("err.flag", 32'(misaligned), 32'd1);
      chk("err.valid", 32'(if_id_valid), 32'd0);
      chk("err.ifpc", if_id_pc, 32'h0);
      step();
      step();
      chk("err.hold", pc, 32'h22);
      chk("err.halted", 32'(halted), 32'd0);
      rst_n = 1'b0;
      step();
      chk_reset("errrst");
      rst_n = 1'b1;
      step();
      chk_fetch("post", 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the datapath. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for the decoder. Also handles stall, redirect (branch/jump) with wrong-path flush, end-of-program halt and misaligned-target detection.

## Interface
Parameters:
- `NUM_INSTRUCTIONS`, 12: number of words in the instruction memory; valid PCs are 0 .. 4*NUM_INSTRUCTIONS-4.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `imem_addr`  output  32  byte address to instruction memory; equals `pc`, combinational from the PC register.
- `imem_instr`  input  32  instruction word returned by memory, same cycle.
- `stall`  input  1  hold PC and IF/ID.
- `redirect`  input  1  branch taken or jump; load `redirect_target` and flush IF/ID.
- `redirect_target`  input  32  new PC.
- `pc`  output  32  current PC register.
- `if_id_instr`  output  32  registered instruction.
- `if_id_pc`  output  32  PC of `if_id_instr`.
- `if_id_valid`  output  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  output  1  fetch stopped at end of program.
- `misaligned`  output  1  sticky; a redirect target had `[1:0] != 0`.
- `fetch_count`  output  32  fetched-instruction counter (see Configuration).

## Operation
- States: RUN, HALT, ERROR. Reset enters RUN.
- Reset values: `pc`=RESET_PC, `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, `halted`=0, `misaligned`=0, `fetch_count`=0.
- Per-edge priority: reset > redirect > stall > normal fetch / halt check.
- RUN, normal (no redirect, no stall, `pc` < 4*NUM_INSTRUCTIONS): `if_id_instr`<=`imem_instr`, `if_id_pc`<=`pc`, `if_id_valid`<=1, `pc`<=`pc`+4.
- RUN, `pc` >= 4*NUM_INSTRUCTIONS (unsigned 32-bit compare), no redirect, no stall: no capture, `if_id_valid`<=0, `pc` holds, state->HALT, `halted`<=1.
- Stall (no redirect): `pc`, `if_id_*` and state hold; the counter does not increment.
- Redirect with aligned target, any state except ERROR: `pc`<=`redirect_target`, `if_id_valid`<=0 (`if_id_instr`/`if_id_pc` hold), state->RUN, `halted`<=0. Redirect overrides a simultaneous stall.
- Redirect with misaligned target: `pc`<=`redirect_target`, `if_id_valid`<=0, `misaligned`<=1, state->ERROR.
- HALT: `if_id_valid`=0; only a redirect or reset leaves it.
- ERROR: terminal until reset; all inputs are ignored, outputs hold, `if_id_valid`=0.
- PC arithmetic is 32-bit and wraps mod 2^32; the halt check fires before any wrap is reachable.

## Timing
- Memory read is combinational: `imem_addr` is valid right after the edge, and the instruction is captured at the next edge. PC to IF/ID latency is 1 cycle.
- Redirect asserted in cycle N: `pc`=target in N+1, `if_id_valid`=0 in N+1, and the first target instruction is valid in N+2.
- Stall asserted in cycle N: outputs in N+1 equal those in N.
- `halted` rises on the edge after the fetch that sees the out-of-range PC.
- Reset asserted mid-operation: all outputs take reset values on that edge regardless of state or other inputs.

## Configuration
- `FETCH_COUNTER_EN` defined: `fetch_count` increments by 1 on every edge where `if_id_valid` is loaded with 1. It saturates at 32'hFFFF_FFFF and is cleared by reset.
- Not defined: no counter register; `fetch_count` is tied to 0. The port is always present.

## Test plan
- Reset, then free run with NUM_INSTRUCTIONS=12 -> `if_id_pc` steps 0,4,...,44 with `if_id_valid`=1; `pc`=48 then `halted`=1 one cycle later; `fetch_count`=12 (macro on) or 0 (macro off).
- Stall held for 3 cycles at `pc`=8 -> `pc`, `if_id_pc`=4 and `if_id_instr` frozen for all 3 cycles; fetch resumes at 8 afterwards.
- Redirect to 0x20 at `pc`=0xC, with stall also high -> next cycle `pc`=0x20 and `if_id_valid`=0; following cycle `if_id_pc`=0x20 and valid=1.
- Run to HALT, then redirect to 0x4 -> `halted`=0, and `if_id_pc`=0x4 is valid two cycles after the redirect.
- Redirect to 0x22 -> `misaligned`=1, `if_id_valid`=0; later redirects are ignored and state stays ERROR until `rst_n`=0.
- `rst_n`=0 for one edge mid-run at `pc`=0x18 -> all outputs take reset values on that edge; the first fetch after release is `if_id_pc`=RESET_PC.
